// File: rtl/program_memory_loadable.sv
// program_memory_loadable
//   Instruction memory for the accumulator CPU. A loader fills it at runtime
//   through a valid/ready stream. Fetches are registered and take one cycle.
//   A fetch at or beyond the loaded length returns HALT (all zeros) and flags
//   an address error.
// Ports
//   i_clk, i_reset          clock, async active-low reset
//   i_address, i_rd_en      fetch request
//   o_instruction, o_valid,
//   o_addr_error            registered fetch result
//   i_load_start            pulse that begins a (re)load
//   i_load_data/valid/last  load stream; o_load_ready accepts a word
//   o_busy                  load in progress (fetches dropped)
//   o_prog_len              number of words loaded
module program_memory_loadable #(
  parameter int NB_INSTRUCTION = 16,
  parameter int NB_ADDRESS     = 11,
  parameter int N_INSTRUCTIONS = 16,
  localparam int NB_LEN        = $clog2(N_INSTRUCTIONS + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NB_ADDRESS-1:0]     i_address,
  input  logic                      i_rd_en,
  output logic [NB_INSTRUCTION-1:0] o_instruction,
  output logic                      o_valid,
  output logic                      o_addr_error,
  input  logic                      i_load_start,
  input  logic [NB_INSTRUCTION-1:0] i_load_data,
  input  logic                      i_load_valid,
  input  logic                      i_load_last,
  output logic                      o_load_ready,
  output logic                      o_busy,
  output logic [NB_LEN-1:0]         o_prog_len
);

  localparam int NB_PTR = $clog2(N_INSTRUCTIONS);
  localparam int NB_CMP = (NB_ADDRESS > NB_LEN) ? NB_ADDRESS : NB_LEN;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] LOAD = 2'b01;
  localparam logic [1:0] RUN  = 2'b10;

  logic [1:0]                r_state;
  logic [NB_PTR-1:0]         r_wptr;
  logic [NB_LEN-1:0]         r_prog_len;
  logic [NB_INSTRUCTION-1:0] r_instruction;
  logic                      r_valid;
  logic                      r_addr_error;
  logic [NB_INSTRUCTION-1:0] r_mem [N_INSTRUCTIONS];

  logic                      w_loading;
  logic                      w_accept;
  logic                      w_wptr_last;
  logic                      w_in_range;
  logic [NB_PTR-1:0]         w_rd_idx;

  assign w_loading   = (r_state == LOAD);
  assign w_accept    = w_loading && i_load_valid;
  assign w_wptr_last = (r_wptr == NB_PTR'(N_INSTRUCTIONS - 1));
  // Full-width compare: high address bits must not alias onto loaded words.
  assign w_in_range  = (NB_CMP'(i_address) < NB_CMP'(r_prog_len));
  // Only used when w_in_range holds, so the low bits are a valid index.
  assign w_rd_idx    = i_address[NB_PTR-1:0];

  // Load FSM
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= IDLE;
      r_wptr     <= '0;
      r_prog_len <= '0;
    end else begin
      case (r_state)
        IDLE, RUN: begin
          if (i_load_start) begin
            r_state    <= LOAD;
            r_wptr     <= '0;
            r_prog_len <= '0;
          end
        end
        LOAD: begin
          if (w_accept) begin
            if (r_prog_len != NB_LEN'(N_INSTRUCTIONS))
              r_prog_len <= r_prog_len + NB_LEN'(1);
            // Last slot auto-terminates; wptr stays parked at N-1.
            if (i_load_last || w_wptr_last)
              r_state <= RUN;
            else
              r_wptr <= r_wptr + NB_PTR'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Storage is not reset; o_prog_len=0 masks stale contents.
  always_ff @(posedge i_clk) begin
    if (w_accept)
      r_mem[r_wptr] <= i_load_data;
  end

  // Fetch path. The read sees pre-edge contents/length, so a fetch issued
  // together with i_load_start completes against the old program.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_instruction <= '0;
      r_valid       <= 1'b0;
      r_addr_error  <= 1'b0;
    end else if (w_loading) begin
      r_valid       <= 1'b0;
      r_instruction <= '0;
    end else if (i_rd_en) begin
      r_valid <= 1'b1;
      if (w_in_range) begin
        r_instruction <= r_mem[w_rd_idx];
        r_addr_error  <= 1'b0;
      end else begin
        r_instruction <= '0;
        r_addr_error  <= 1'b1;
      end
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign o_instruction = r_instruction;
  assign o_valid       = r_valid;
  assign o_addr_error  = r_addr_error;
  assign o_load_ready  = w_loading;
  assign o_busy        = w_loading;
  assign o_prog_len    = r_prog_len;

endmodule

// File: tb/tb_program_memory_loadable.sv
module tb_program_memory_loadable;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [10:0] i_address = '0;
  logic        i_rd_en = 1'b0;
  logic [15:0] o_instruction;
  logic        o_valid;
  logic        o_addr_error;
  logic        i_load_start = 1'b0;
  logic [15:0] i_load_data = '0;
  logic        i_load_valid = 1'b0;
  logic        i_load_last = 1'b0;
  logic        o_load_ready;
  logic        o_busy;
  logic [4:0]  o_prog_len;

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];  // {instruction, addr_error}

  program_memory_loadable dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_address(i_address), .i_rd_en(i_rd_en),
    .o_instruction(o_instruction), .o_valid(o_valid), .o_addr_error(o_addr_error),
    .i_load_start(i_load_start), .i_load_data(i_load_data),
    .i_load_valid(i_load_valid), .i_load_last(i_load_last),
    .o_load_ready(o_load_ready), .o_busy(o_busy), .o_prog_len(o_prog_len)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every valid fetch result pops one expectation.
  always @(negedge i_clk) begin
    if (o_valid === 1'b1) begin
      logic [16:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_fetch got %h/%b expected none", o_instruction, o_addr_error);
      end else begin
        e = exp_q.pop_front();
        if ({o_instruction, o_addr_error} !== e) begin
          errors++;
          $display("FAIL fetch got %h/%b expected %h/%b", o_instruction, o_addr_error,
                   e[16:1], e[0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic fetch(input logic [10:0] a, input logic [15:0] ins, input logic err);
    i_address = a; i_rd_en = 1'b1;
    exp_q.push_back({ins, err});
    tick();
    i_rd_en = 1'b0;
  endtask

  task automatic start_load();
    i_load_start = 1'b1;
    tick();
    i_load_start = 1'b0;
  endtask

  task automatic load_word(input logic [15:0] d, input logic last);
    int n = 0;
    i_load_data = d; i_load_valid = 1'b1; i_load_last = last;
    while (o_load_ready !== 1'b1 && n < 20) begin tick(); n++; end
    if (o_load_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL load_ready_timeout got %b expected 1", o_load_ready);
    end
    tick();
    i_load_valid = 1'b0; i_load_last = 1'b0;
  endtask

  initial begin
    logic [15:0] prog [5];
    prog[0] = 16'h1805; prog[1] = 16'h0800; prog[2] = 16'h1806;
    prog[3] = 16'h2000; prog[4] = 16'h0000;

    // T1 reset state and fetch on empty memory
    repeat (3) tick();
    chk("rst_instr", 32'(o_instruction), 0);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_err", 32'(o_addr_error), 0);
    chk("rst_ready", 32'(o_load_ready), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_len", 32'(o_prog_len), 0);
    i_reset = 1'b1;
    tick();
    fetch(11'd0, 16'h0000, 1'b1);

    // T2 five-word program with explicit last
    start_load();
    chk("t2_busy", 32'(o_busy), 1);
    chk("t2_ready", 32'(o_load_ready), 1);
    for (int i = 0; i < 5; i++) load_word(prog[i], i == 4);
    chk("t2_len", 32'(o_prog_len), 5);
    chk("t2_busy_after", 32'(o_busy), 0);
    for (int i = 0; i < 5; i++) fetch(11'(i), prog[i], 1'b0);
    fetch(11'd5, 16'h0000, 1'b1);

    // T3 toggling valid, no last: auto-terminates after 16 words
    start_load();
    for (int i = 0; i < 17; i++) begin
      chk("t3_ready", 32'(o_load_ready), (i < 16) ? 1 : 0);
      i_load_data = 16'hA000 + 16'(i); i_load_valid = 1'b1;
      tick();
      i_load_valid = 1'b0;
      tick();
    end
    chk("t3_len", 32'(o_prog_len), 16);
    chk("t3_busy", 32'(o_busy), 0);
    fetch(11'd0, 16'hA000, 1'b0);
    fetch(11'd15, 16'hA00F, 1'b0);
    fetch(11'd16, 16'h0000, 1'b1);

    // T4 no wrap on high addresses
    fetch(11'h7FF, 16'h0000, 1'b1);
    fetch(11'h40F, 16'h0000, 1'b1);

    // T5 reset in the middle of a load
    start_load();
    for (int i = 0; i < 3; i++) load_word(16'hB000 + 16'(i), 1'b0);
    chk("t5_len_pre", 32'(o_prog_len), 3);
    #2 i_reset = 1'b0;
    #1;
    chk("t5_busy", 32'(o_busy), 0);
    chk("t5_len", 32'(o_prog_len), 0);
    tick();
    i_reset = 1'b1;
    tick();
    fetch(11'd0, 16'h0000, 1'b1);

    // Load with ignored restart, dangling last, and a dropped fetch
    start_load();
    load_word(16'hC000, 1'b0);
    i_load_start = 1'b1; i_load_last = 1'b1;
    tick();
    i_load_start = 1'b0; i_load_last = 1'b0;
    chk("ld_restart_ignored", 32'(o_prog_len), 1);
    chk("ld_last_no_valid", 32'(o_busy), 1);
    i_address = 11'd0; i_rd_en = 1'b1;
    tick();
    i_rd_en = 1'b0;
    chk("ld_fetch_dropped_v", 32'(o_valid), 0);
    chk("ld_fetch_dropped_i", 32'(o_instruction), 0);
    for (int i = 1; i < 4; i++) load_word(16'hC000 + 16'(i), i == 3);
    chk("ld_len", 32'(o_prog_len), 4);

    // T6 fetch and load_start on the same edge
    i_load_start = 1'b1;
    fetch(11'd2, 16'hC002, 1'b0);
    i_load_start = 1'b0;
    chk("t6_busy", 32'(o_busy), 1);
    chk("t6_len", 32'(o_prog_len), 0);
    load_word(16'hD000, 1'b1);
    fetch(11'd0, 16'hD000, 1'b0);
    fetch(11'd1, 16'h0000, 1'b1);

    repeat (3) tick();
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule
